if_pc_gen: RTL and testbench

IF_PC_GEN -- requirements
Module: if_pc_gen

---
 rtl/if_pc_gen.sv | 215 +++++++++++++++++++++
 tb/tb_if_pc_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: issues word-aligned fetches under a two-entry credit,
// tracks requests in flight, drops responses killed by a redirect and buffers the rest for ID.
module if_pc_gen #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         o_imem_req,
    output logic [N-1:0] o_imem_addr,
    input  logic         i_imem_gnt,
    input  logic         i_imem_rvalid,
    input  logic [31:0]  i_imem_rdata,
    output logic [N-1:0] o_bpu_pc,
    input  logic         i_bpu_prediction,
    input  logic [N-1:0] i_bpu_target,
    input  logic         i_redirect,
    input  logic [N-1:0] i_redirect_pc,
    input  logic         i_stall,
    output logic         o_if_valid,
    output logic [31:0]  o_if_instr,
    output logic [N-1:0] o_if_pc,
    output logic         o_if_pred_taken
);

    localparam logic [31:0]  NOP_INSTR  = 32'h0000_0013;
    localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};
    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    function automatic logic [N-1:0] align_word(input logic [N-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    logic [N-1:0] pc_r;
    logic [1:0]   stale_r;

    // In-flight metadata, slot 0 is the oldest outstanding request
    logic [N-1:0] ifl0_pc_r;
    logic         ifl0_pred_r;
    logic [N-1:0] ifl1_pc_r;
    logic         ifl1_pred_r;
    logic [1:0]   ifl_cnt_r;

    // Response buffer, slot 0 is the head presented to ID
    logic [31:0]  buf0_instr_r;
    logic [N-1:0] buf0_pc_r;
    logic         buf0_pred_r;
    logic [31:0]  buf1_instr_r;
    logic [N-1:0] buf1_pc_r;
    logic         buf1_pred_r;
    logic [1:0]   buf_cnt_r;

    logic         credit_ok_s;
    logic         req_s;
    logic         hs_s;
    logic         rsp_take_s;
    logic         if_pop_s;
    logic [2:0]   stale_sum_s;
    logic [2:0]   stale_dec_s;
    logic [N-1:0] pc_next_s;
    logic [1:0]   stale_next_s;

    // Request credit, handshake, response routing and next PC / stale count
    always_comb begin
        credit_ok_s = ({1'b0, ifl_cnt_r} + {1'b0, buf_cnt_r}) < 3'd2;
        req_s       = rst_n & ~i_redirect & credit_ok_s;
        hs_s        = req_s & i_imem_gnt;
        rsp_take_s  = i_imem_rvalid & ~i_redirect & (stale_r == 2'd0) & (ifl_cnt_r != 2'd0);
        if_pop_s    = (buf_cnt_r != 2'd0) & ~i_stall;
        stale_sum_s = {1'b0, stale_r} + {1'b0, ifl_cnt_r};
        stale_dec_s = stale_sum_s - 3'd1;

        if (i_redirect) begin
            pc_next_s = align_word(i_redirect_pc);
        end else if (hs_s) begin
            if (i_bpu_prediction) begin
                pc_next_s = align_word(i_bpu_target);
            end else begin
                pc_next_s = pc_r + PC_STEP;
            end
        end else begin
            pc_next_s = pc_r;
        end

        // A response arriving with the redirect belongs to the oldest killed request.
        // The memory side must keep no more than three killed responses pending.
        if (i_redirect) begin
            if (i_imem_rvalid && (stale_sum_s != 3'd0)) begin
                stale_next_s = stale_dec_s[1:0];
            end else begin
                stale_next_s = stale_sum_s[1:0];
            end
        end else if (i_imem_rvalid && (stale_r != 2'd0)) begin
            stale_next_s = stale_r - 2'd1;
        end else begin
            stale_next_s = stale_r;
        end
    end

    // PC and stale-response counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= align_word(RESET_PC);
            stale_r <= 2'd0;
        end else begin
            pc_r    <= pc_next_s;
            stale_r <= stale_next_s;
        end
    end

    // In-flight metadata FIFO: push on handshake, pop on an accepted response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifl0_pc_r   <= {N{1'b0}};
            ifl0_pred_r <= 1'b0;
            ifl1_pc_r   <= {N{1'b0}};
            ifl1_pred_r <= 1'b0;
            ifl_cnt_r   <= 2'd0;
        end else if (i_redirect) begin
            ifl_cnt_r <= 2'd0;
        end else begin
            case (ifl_cnt_r)
                2'd0: begin
                    if (hs_s) begin
                        ifl0_pc_r   <= pc_r;
                        ifl0_pred_r <= i_bpu_prediction;
                        ifl_cnt_r   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (hs_s && rsp_take_s) begin
                        ifl0_pc_r   <= pc_r;
                        ifl0_pred_r <= i_bpu_prediction;
                    end else if (hs_s) begin
                        ifl1_pc_r   <= pc_r;
                        ifl1_pred_r <= i_bpu_prediction;
                        ifl_cnt_r   <= 2'd2;
                    end else if (rsp_take_s) begin
                        ifl_cnt_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (rsp_take_s) begin
                        ifl0_pc_r   <= ifl1_pc_r;
                        ifl0_pred_r <= ifl1_pred_r;
                        ifl_cnt_r   <= 2'd1;
                    end
                end
                default: begin
                    ifl_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // Response buffer: push accepted responses, pop when ID takes the head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf0_instr_r <= NOP_INSTR;
            buf0_pc_r    <= {N{1'b0}};
            buf0_pred_r  <= 1'b0;
            buf1_instr_r <= NOP_INSTR;
            buf1_pc_r    <= {N{1'b0}};
            buf1_pred_r  <= 1'b0;
            buf_cnt_r    <= 2'd0;
        end else if (i_redirect) begin
            buf_cnt_r <= 2'd0;
        end else begin
            case (buf_cnt_r)
                2'd0: begin
                    if (rsp_take_s) begin
                        buf0_instr_r <= i_imem_rdata;
                        buf0_pc_r    <= ifl0_pc_r;
                        buf0_pred_r  <= ifl0_pred_r;
                        buf_cnt_r    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rsp_take_s && if_pop_s) begin
                        buf0_instr_r <= i_imem_rdata;
                        buf0_pc_r    <= ifl0_pc_r;
                        buf0_pred_r  <= ifl0_pred_r;
                    end else if (rsp_take_s) begin
                        buf1_instr_r <= i_imem_rdata;
                        buf1_pc_r    <= ifl0_pc_r;
                        buf1_pred_r  <= ifl0_pred_r;
                        buf_cnt_r    <= 2'd2;
                    end else if (if_pop_s) begin
                        buf_cnt_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (if_pop_s) begin
                        buf0_instr_r <= buf1_instr_r;
                        buf0_pc_r    <= buf1_pc_r;
                        buf0_pred_r  <= buf1_pred_r;
                        buf_cnt_r    <= 2'd1;
                    end
                end
                default: begin
                    buf_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign o_imem_req      = req_s;
    assign o_imem_addr     = pc_r;
    assign o_bpu_pc        = pc_r;
    assign o_if_valid      = (buf_cnt_r != 2'd0);
    assign o_if_instr      = buf0_instr_r;
    assign o_if_pc         = buf0_pc_r;
    assign o_if_pred_taken = buf0_pred_r;

endmodule

// File: tb/tb_if_pc_gen.sv
// Randomized bench for if_pc_gen: an in-order memory model with variable latency, a
// fetch-stream reference model and a scoreboard checked by an independent monitor.
module tb_if_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_bpu_pc;
    logic        i_bpu_prediction;
    logic [31:0] i_bpu_target;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        o_if_pred_taken;

    if_pc_gen #(.N(32), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_gnt      (i_imem_gnt),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .o_bpu_pc        (o_bpu_pc),
        .i_bpu_prediction(i_bpu_prediction),
        .i_bpu_target    (i_bpu_target),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .i_stall         (i_stall),
        .o_if_valid      (o_if_valid),
        .o_if_instr      (o_if_instr),
        .o_if_pc         (o_if_pc),
        .o_if_pred_taken (o_if_pred_taken)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];
    int   ready_cnt;
    int   epoch;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   n_pops;
    logic [31:0] model_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares the head presented to ID against the scoreboard
    initial begin
        logic prev_rst_n;
        exp_t e;
        prev_rst_n = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (!prev_rst_n) begin
                check("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
                check("rst_if_instr", o_if_instr, 32'h0000_0013);
                check("rst_if_pc", o_if_pc, 32'd0);
                check("rst_if_pred", {31'd0, o_if_pred_taken}, 32'd0);
            end else if (rst_n) begin
                check("if_valid", {31'd0, o_if_valid}, {31'd0, ready_cnt > 0});
                if (ready_cnt > 0 && !i_stall && !i_redirect) begin
                    e = exp_q.pop_front();
                    ready_cnt--;
                    n_pops++;
                    check("if_pc", o_if_pc, e.pc);
                    check("if_instr", o_if_instr, instr_of(e.pc));
                    check("if_pred", {31'd0, o_if_pred_taken}, {31'd0, e.pred});
                end
            end
            prev_rst_n = rst_n;
        end
    end

    // Driver, memory model and fetch-stream reference model
    initial begin
        int   p_gnt, p_rv, p_stall, p_redir, p_pred, maxlat;
        logic rv, redir, exp_req, prev_rst_n;
        mem_t rv_ent;
        exp_t e;
        mem_t m;

        rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'd0;
        i_bpu_prediction = 1'b0; i_bpu_target = 32'd0; i_redirect = 1'b0;
        i_redirect_pc = 32'd0; i_stall = 1'b0;
        n_checks = 0; n_errors = 0; n_pops = 0; ready_cnt = 0; epoch = 0; cyc = 0;
        model_pc = RESET_PC; prev_rst_n = 1'b1;
        rv_ent = '{addr: 32'd0, due: 0, epoch: 0};

        for (int ph = 0; ph < 8; ph++) begin
            case (ph)
                0: begin p_gnt = 100; p_rv = 100; maxlat = 0; p_stall = 0;  p_redir = 0;  p_pred = 0;  end
                1: begin p_gnt = 100; p_rv = 100; maxlat = 1; p_stall = 70; p_redir = 0;  p_pred = 0;  end
                2: begin p_gnt = 25;  p_rv = 80;  maxlat = 2; p_stall = 20; p_redir = 0;  p_pred = 30; end
                3: begin p_gnt = 90;  p_rv = 90;  maxlat = 3; p_stall = 10; p_redir = 8;  p_pred = 50; end
                default: begin
                    p_gnt = $urandom_range(30, 100); p_rv = $urandom_range(40, 100);
                    maxlat = $urandom_range(0, 3); p_stall = $urandom_range(0, 60);
                    p_redir = $urandom_range(0, 15); p_pred = $urandom_range(0, 60);
                end
            endcase
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                cyc++;
                rst_n = (c >= 3);
                rv = 1'b0;
                if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc &&
                    $urandom_range(0, 99) < p_rv) begin
                    rv = 1'b1;
                    rv_ent = mem_q.pop_front();
                end
                i_imem_rvalid    = rv;
                i_imem_rdata     = rv ? instr_of(rv_ent.addr) : $urandom;
                i_imem_gnt       = ($urandom_range(0, 99) < p_gnt);
                i_stall          = ($urandom_range(0, 99) < p_stall);
                i_bpu_prediction = ($urandom_range(0, 99) < p_pred);
                case ($urandom_range(0, 2))
                    0:       i_bpu_target = 32'h0000_0080;
                    1:       i_bpu_target = 32'hFFFF_FFFE;
                    default: i_bpu_target = $urandom;
                endcase
                // keep the number of killed responses still pending at memory within three
                redir = rst_n && ($urandom_range(0, 99) < p_redir) && (mem_q.size() <= 3);
                i_redirect = redir;
                case ($urandom_range(0, 3))
                    0:       i_redirect_pc = 32'h0000_0203;
                    1:       i_redirect_pc = 32'hFFFF_FFF8;
                    2:       i_redirect_pc = 32'hFFFF_FFFF;
                    default: i_redirect_pc = $urandom;
                endcase

                #1;
                exp_req = rst_n && !redir && (exp_q.size() < 2);
                check("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
                if (rst_n || !prev_rst_n) begin
                    check("imem_addr", o_imem_addr, model_pc);
                    check("bpu_pc", o_bpu_pc, model_pc);
                end
                if (exp_req && i_imem_gnt) begin
                    e = '{pc: model_pc, pred: i_bpu_prediction};
                    exp_q.push_back(e);
                    m = '{addr: model_pc, due: cyc + 1 + $urandom_range(0, maxlat), epoch: epoch};
                    mem_q.push_back(m);
                    model_pc = i_bpu_prediction ? (i_bpu_target & 32'hFFFF_FFFC) : model_pc + 32'd4;
                end

                #2;
                if (!rst_n) begin
                    exp_q.delete();
                    mem_q.delete();
                    ready_cnt = 0;
                    epoch++;
                    model_pc = RESET_PC;
                end else begin
                    if (rv && !redir && rv_ent.epoch == epoch) ready_cnt++;
                    if (redir) begin
                        exp_q.delete();
                        ready_cnt = 0;
                        epoch++;
                        model_pc = i_redirect_pc & 32'hFFFF_FFFC;
                    end
                end
                prev_rst_n = rst_n;
            end
        end

        @(negedge clk);
        check("progress", {31'd0, n_pops > 200}, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
